// File: rtl/msx_mouse_port.sv
// MiSTer ps2_mouse packets to MSX nibble-serial mouse protocol (X-hi, X-lo, Y-hi, Y-lo per strobe toggle).
// Optional MOUSE_HALFSPEED_EN: each read returns half the accumulated motion, odd residue kept.
module msx_mouse_port #(
    parameter int TIMEOUT_CYC = 32000,
    parameter int ACC_W       = 10
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        strobe,
    output logic [5:0]  data,
    output logic        active
);
    localparam int SUM_W = ACC_W + 3;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef MOUSE_HALFSPEED_EN
    localparam int SUB_SHIFT = 1;
`else
    localparam int SUB_SHIFT = 0;
`endif
    localparam logic signed [ACC_W-1:0] POS127  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] NEG127  = -ACC_W'(127);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

    typedef enum logic [1:0] {X_HI, X_LO, Y_HI, Y_LO} idx_t;

    idx_t                     idx_reg;
    logic                     tog_reg, stb_reg, active_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [ACC_W-1:0]  acc_x_reg, acc_y_reg, acc_x_next, acc_y_next;
    logic signed [7:0]        lx_reg, ly_reg, lx_new, ly_new;
    logic [1:0]               btn_reg;
    logic [3:0]               nib_reg;
    logic signed [8:0]        dx9, dy9;
    logic signed [SUM_W-1:0]  sum_x, sum_y;
    logic                     packet, stb_edge, latch;

    // Overflow flags replace the motion with full-scale travel in the signed direction.
    function automatic logic signed [8:0] axis_delta(input logic sgn, input logic ovf,
                                                     input logic [7:0] mag);
        return ovf ? (sgn ? -9'sd255 : 9'sd255) : $signed({sgn, mag});
    endfunction

    function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] v);
`ifdef MOUSE_HALFSPEED_EN
        logic signed [ACC_W-1:0] t;
        t = v + $signed({{(ACC_W-1){1'b0}}, v[ACC_W-1]});
        return t >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > POS127)
            return 8'sd127;
        else if (v < NEG127)
            return -8'sd127;
        else
            return v[7:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
        if (s > ACC_MAX)
            return ACC_MAX[ACC_W-1:0];
        else if (s < ACC_MIN)
            return ACC_MIN[ACC_W-1:0];
        else
            return s[ACC_W-1:0];
    endfunction

    assign packet   = ps2_mouse[24] ^ tog_reg;
    assign stb_edge = strobe ^ stb_reg;
    assign latch    = stb_edge && (idx_reg == X_HI);
    assign dx9      = axis_delta(ps2_mouse[4], ps2_mouse[6], ps2_mouse[15:8]);
    assign dy9      = axis_delta(ps2_mouse[5], ps2_mouse[7], ps2_mouse[23:16]);
    assign lx_new   = sat8(scale(acc_x_reg));
    assign ly_new   = sat8(scale(acc_y_reg));

    // Latch uses the pre-packet accumulator; a coincident packet delta is still folded in.
    always_comb begin
        sum_x = SUM_W'(acc_x_reg);
        sum_y = SUM_W'(acc_y_reg);
        if (packet) begin
            sum_x = sum_x - SUM_W'(dx9);
            sum_y = sum_y + SUM_W'(dy9);
        end
        if (latch) begin
            sum_x = sum_x - (SUM_W'(lx_new) <<< SUB_SHIFT);
            sum_y = sum_y - (SUM_W'(ly_new) <<< SUB_SHIFT);
        end
        acc_x_next = sat_acc(sum_x);
        acc_y_next = sat_acc(sum_y);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            idx_reg    <= X_HI;
            tog_reg    <= ps2_mouse[24];
            stb_reg    <= strobe;
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            acc_x_reg  <= '0;
            acc_y_reg  <= '0;
            lx_reg     <= '0;
            ly_reg     <= '0;
            btn_reg    <= 2'b11;
            nib_reg    <= 4'h0;
        end else begin
            tog_reg    <= ps2_mouse[24];
            stb_reg    <= strobe;
            active_reg <= packet;
            acc_x_reg  <= acc_x_next;
            acc_y_reg  <= acc_y_next;
            if (packet)
                btn_reg <= ~{ps2_mouse[1], ps2_mouse[0]};
            if (stb_edge) begin
                cnt_reg <= '0;
                case (idx_reg)
                    X_HI: begin
                        lx_reg  <= lx_new;
                        ly_reg  <= ly_new;
                        nib_reg <= lx_new[7:4];
                        idx_reg <= X_LO;
                    end
                    X_LO: begin
                        nib_reg <= lx_reg[3:0];
                        idx_reg <= Y_HI;
                    end
                    Y_HI: begin
                        nib_reg <= ly_reg[7:4];
                        idx_reg <= Y_LO;
                    end
                    default: begin
                        nib_reg <= ly_reg[3:0];
                        idx_reg <= X_HI;
                    end
                endcase
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYC)) begin
                // Host abandoned a read: restart at X_HI, drop the unserved latch.
                idx_reg <= X_HI;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign data   = {btn_reg, nib_reg};
    assign active = active_reg;
endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed bench for msx_mouse_port: hand-computed nibble reads, buttons, timeout, reset and saturation.
`timescale 1ns/1ps
module tb_msx_mouse_port;
    localparam int TO = 100;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic        strobe;
    logic [5:0]  data;
    logic        active;

    int checks = 0;
    int errors = 0;

    msx_mouse_port #(.TIMEOUT_CYC(TO), .ACC_W(10)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_mouse (ps2_mouse),
        .strobe    (strobe),
        .data      (data),
        .active    (active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        ps2_mouse = {~ps2_mouse[24], dy, dx, st};
        tick();
    endtask

    task automatic read_nib(output logic [3:0] n);
        strobe = ~strobe;
        tick();
        n = data[3:0];
    endtask

    task automatic read_xy(output logic [7:0] x, output logic [7:0] y);
        logic [3:0] a, b, c, d;
        read_nib(a);
        read_nib(b);
        read_nib(c);
        read_nib(d);
        x = {a, b};
        y = {c, d};
    endtask

    initial begin
        logic [7:0] x, y;
        logic [3:0] n;
        reset_n   = 1'b0;
        ps2_mouse = '0;
        strobe    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("reset_data", 32'(data), 32'h30);
        check("reset_active", 32'(active), 32'h0);

        // dX=+5 -> accX=-5 (0xFB), dY=+3
        send(8'h08, 8'h05, 8'h03);
        check("pkt_active", 32'(active), 32'h1);
        read_xy(x, y);
        check("basic_x", 32'(x), 32'hFB);
        check("basic_y", 32'(y), 32'h03);
        check("active_cleared", 32'(active), 32'h0);

        // buttons follow packets independently of reads
        send(8'h09, 8'h00, 8'h00);
        check("btn_left_down", 32'(data[5:4]), 32'h2);
        check("btn_active_pulse", 32'(active), 32'h1);
        tick();
        check("btn_active_one_clk", 32'(active), 32'h0);
        send(8'h08, 8'h00, 8'h00);
        check("btn_left_up", 32'(data[5:4]), 32'h3);

        // three dX=-100 packets -> accX=+300, drained 127,127,46
        repeat (3) send(8'h18, 8'h9C, 8'h00);
        read_xy(x, y);
        check("sat8_read1", 32'(x), 32'h7F);
        check("sat8_read1_y", 32'(y), 32'h00);
        read_xy(x, y);
        check("sat8_read2", 32'(x), 32'h7F);
        read_xy(x, y);
        check("sat8_read3", 32'(x), 32'h2E);

        // accX=+16, then dX=+1 arrives on the same clk as the X_HI strobe edge
        send(8'h18, 8'hF0, 8'h00);
        ps2_mouse = {~ps2_mouse[24], 8'h00, 8'h01, 8'h08};
        strobe    = ~strobe;
        tick();
        x[7:4] = data[3:0];
        read_nib(n);
        x[3:0] = n;
        read_nib(n);
        read_nib(n);
        check("coincident_latch", 32'(x), 32'h10);
        read_xy(x, y);
        check("coincident_residue", 32'(x), 32'hFF);

        // abandoned read: timeout resyncs to X_HI, old latch discarded
        send(8'h08, 8'h05, 8'h00);
        read_nib(n);
        check("to_xhi", 32'(n), 32'hF);
        read_nib(n);
        check("to_xlo", 32'(n), 32'hB);
        repeat (TO + 1) tick();
        check("to_data_held", 32'(data[3:0]), 32'hB);
        send(8'h08, 8'h00, 8'h01);
        read_xy(x, y);
        check("to_fresh_x", 32'(x), 32'h00);
        check("to_fresh_y", 32'(y), 32'h01);

        // reset in the middle of a read (idx=2), with toggles changing during reset
        send(8'h08, 8'h05, 8'h03);
        read_nib(n);
        read_nib(n);
        reset_n   = 1'b0;
        strobe    = ~strobe;
        ps2_mouse = {~ps2_mouse[24], 8'h00, 8'h00, 8'h09};
        tick();
        tick();
        check("midreset_data", 32'(data), 32'h30);
        check("midreset_active", 32'(active), 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_reset_no_pkt", 32'(active), 32'h0);
        check("post_reset_no_edge", 32'(data), 32'h30);
        send(8'h08, 8'h05, 8'h00);
        read_xy(x, y);
        check("post_reset_x", 32'(x), 32'hFB);
        check("post_reset_y", 32'(y), 32'h00);

`ifdef MOUSE_HALFSPEED_EN
        send(8'h08, 8'h05, 8'h00);
        read_xy(x, y);
        check("half_read1", 32'(x), 32'hFE);
        read_xy(x, y);
        check("half_read2", 32'(x), 32'h00);
`else
        // six Xovf packets (dX=-255) saturate accX at +511: 127 x4 then 3
        repeat (6) send(8'h58, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_xy(x, y);
            check("accsat_full", 32'(x), 32'h7F);
        end
        read_xy(x, y);
        check("accsat_rest", 32'(x), 32'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
